// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller.
// Contents: default widths for the data, address and counter buses,
// and the controller FSM state enumeration.
package cache_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        MEM_READ  = 3'd2,
        FILL      = 3'd3,
        MEM_WRITE = 3'd4,
        DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter used for the hit and miss statistics.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the count
//   inc   - increment request for this cycle
//   count - current value; holds at all-ones instead of wrapping
module sat_counter
    import cache_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache controller, write-through with write-allocate.
// The cache array itself is external and answers combinationally on
// cache_hit/cache_rdata for the address presented on cache_addr.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             - CPU request, sampled while cpu_ready=1
//   cpu_ready/ack/rdata               - CPU handshake and read result
//   cache_addr/wdata/we               - cache array write/lookup port
//   cache_rdata/hit                   - cache lookup result
//   mem_req/we/addr/wdata             - backing memory request
//   mem_ack/rdata                     - backing memory completion
//   hit_count/miss_count              - saturating read hit/miss counters
module cache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_we,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    state_t                r_state;
    logic                  r_we;
    logic                  r_cpu_ready;
    logic                  r_cpu_ack;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [ADDR_WIDTH-1:0] r_cache_addr;
    logic [DATA_WIDTH-1:0] r_cache_wdata;
    logic                  r_cache_we;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_hit_inc;
    logic                  w_miss_inc;
    logic                  w_mem_done;

    // Lookup outcome is only meaningful in COMPARE for a read.
    assign w_hit_inc  = (r_state == COMPARE) && !r_we &&  cache_hit;
    assign w_miss_inc = (r_state == COMPARE) && !r_we && !cache_hit;
    // A memory ack only counts while our own request is outstanding.
    assign w_mem_done = r_mem_req && mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_cpu_ready   <= 1'b1;
            r_cpu_ack     <= 1'b0;
            r_cpu_rdata   <= '0;
            r_cache_addr  <= '0;
            r_cache_wdata <= '0;
            r_cache_we    <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_cpu_ack  <= 1'b0;
            r_cache_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we          <= cpu_we;
                        r_cache_addr  <= cpu_addr;
                        r_cache_wdata <= cpu_wdata;
                        // Writes allocate: the array is written during COMPARE.
                        r_cache_we    <= cpu_we;
                        r_cpu_ready   <= 1'b0;
                        r_state       <= COMPARE;
                    end
                end
                COMPARE: begin
                    r_mem_addr  <= r_cache_addr;
                    r_mem_wdata <= r_cache_wdata;
                    if (r_we) begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_state   <= MEM_WRITE;
                    end else if (cache_hit) begin
                        r_cpu_rdata <= cache_rdata;
                        r_cpu_ack   <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b0;
                        r_state   <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (w_mem_done) begin
                        r_mem_req     <= 1'b0;
                        // Fill word is held here for the FILL write and the CPU copy.
                        r_cache_wdata <= mem_rdata;
                        r_cache_we    <= 1'b1;
                        r_state       <= FILL;
                    end
                end
                FILL: begin
                    r_cpu_rdata <= r_cache_wdata;
                    r_cpu_ack   <= 1'b1;
                    r_state     <= DONE;
                end
                MEM_WRITE: begin
                    if (w_mem_done) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_cpu_ack <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_cpu_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_cpu_ready <= 1'b1;
                    r_mem_req   <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hit_inc),
        .count (hit_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_miss_inc),
        .count (miss_count)
    );

    assign cpu_ready   = r_cpu_ready;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign cache_addr  = r_cache_addr;
    assign cache_wdata = r_cache_wdata;
    assign cache_we    = r_cache_we;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: directed scenarios followed by random
// traffic. A behavioural model (line residency, memory image, counters)
// predicts each transaction; a monitor compares every ack, cache write
// and memory request cycle against the oldest outstanding expectation.
module tb_cache_controller;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_we;
    logic [DW-1:0] cache_rdata;
    logic          cache_hit;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    cache_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- external cache array: 8 lines, index addr[4:2] ----------------
    logic          cv [8];
    logic [10:0]   ct [8];
    logic [DW-1:0] cd [8];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) cv[i] <= 1'b0;
        end else if (cache_we) begin
            cv[cache_addr[4:2]] <= 1'b1;
            ct[cache_addr[4:2]] <= cache_addr[15:5];
            cd[cache_addr[4:2]] <= cache_wdata;
        end
    end

    assign cache_hit   = cv[cache_addr[4:2]] && (ct[cache_addr[4:2]] == cache_addr[15:5]);
    assign cache_rdata = cd[cache_addr[4:2]];

    // ---------------- backing memory: 64 words, addr[7:2] ----------------
    logic [DW-1:0] mem_phys [64];
    int            mem_delay = 1;
    bit            spurious_en = 1'b0;

    initial begin
        int mcnt;
        mcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                mcnt++;
                if (mcnt >= mem_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_phys[mem_addr[7:2]] = mem_wdata;
                    else        mem_rdata = mem_phys[mem_addr[7:2]];
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                mcnt      = 0;
                mem_ack   = spurious_en && ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_hit;
        int            exp_hits;
        int            exp_misses;
        int            acc_cyc;
    } txn_t;

    txn_t          sb_q[$];
    logic [DW-1:0] mem_ref [64];
    logic          res_v [8];
    logic [AW-1:0] res_a [8];
    int            m_hits   = 0;
    int            m_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) res_v[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        sb_q.delete();
    endtask

    // Predict the outcome from the rules: a read hits iff its line currently
    // holds this exact address; every access leaves its address resident.
    task automatic push_expect(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        txn_t t;
        int   idx;
        idx          = int'(addr[4:2]);
        t.we         = we;
        t.addr       = addr;
        t.wdata      = wdata;
        t.exp_hit    = !we && res_v[idx] && (res_a[idx] == addr);
        t.exp_rdata  = we ? wdata : mem_ref[addr[7:2]];
        if (!we) begin
            if (t.exp_hit) m_hits   = (m_hits   < CMAX) ? m_hits + 1   : CMAX;
            else           m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
        end
        if (we) mem_ref[addr[7:2]] = wdata;
        res_v[idx]   = 1'b1;
        res_a[idx]   = addr;
        t.exp_hits   = m_hits;
        t.exp_misses = m_misses;
        t.acc_cyc    = cyc;
        sb_q.push_back(t);
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input bit hold, input bit wait_ack);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cpu_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cpu_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        push_expect(we, addr, wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        if (!hold) begin
            cpu_req   = 1'b0;
            cpu_we    = $urandom_range(0, 1);
            cpu_addr  = AW'($urandom);
            cpu_wdata = $urandom;
        end
        if (wait_ack) begin
            guard = 0;
            while (guard < 200) begin
                @(negedge clk);
                if (cpu_ack) break;
                guard++;
            end
            cpu_req = 1'b0;
            if (guard >= 200) begin
                chk("ack_timeout", 0, 1);
                sb_q.delete();
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        int            n_mem;
        int            n_cwe;
        logic [DW-1:0] last_rdata;
        txn_t          t;
        int            lat;
        n_mem      = 0;
        n_cwe      = 0;
        last_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_mem      = 0;
                n_cwe      = 0;
                last_rdata = '0;
            end else begin
                if (mem_req) begin
                    chk("cache_we_during_mem", cache_we, 0);
                    if (sb_q.size() == 0) begin
                        chk("mem_req_without_txn", 1, 0);
                    end else begin
                        n_mem++;
                        chk("mem_addr", mem_addr, sb_q[0].addr);
                        chk("mem_we", mem_we, sb_q[0].we);
                        if (sb_q[0].we) chk("mem_wdata", mem_wdata, sb_q[0].wdata);
                    end
                end
                if (cache_we) begin
                    if (sb_q.size() == 0) begin
                        chk("cache_we_without_txn", 1, 0);
                    end else begin
                        n_cwe++;
                        chk("cache_addr", cache_addr, sb_q[0].addr);
                        chk("cache_wdata", cache_wdata, sb_q[0].exp_rdata);
                        if (sb_q[0].we) chk("cache_we_cycle_wr", cyc - sb_q[0].acc_cyc, 1);
                        else            chk("cache_we_cycle_fill", cyc - sb_q[0].acc_cyc, 2 + n_mem);
                    end
                end
                if (cpu_ack) begin
                    if (sb_q.size() == 0) begin
                        chk("ack_without_txn", 1, 0);
                    end else begin
                        t   = sb_q.pop_front();
                        lat = cyc - t.acc_cyc;
                        if (t.we) begin
                            chk("wr_latency", lat, 2 + n_mem);
                            chk("wr_mem_used", n_mem != 0, 1);
                            chk("wr_cache_we_count", n_cwe, 1);
                            chk("wr_rdata_held", cpu_rdata, last_rdata);
                        end else if (t.exp_hit) begin
                            chk("hit_latency", lat, 2);
                            chk("hit_mem_cycles", n_mem, 0);
                            chk("hit_cache_we_count", n_cwe, 0);
                            chk("hit_rdata", cpu_rdata, t.exp_rdata);
                        end else begin
                            chk("miss_latency", lat, 3 + n_mem);
                            chk("miss_mem_used", n_mem != 0, 1);
                            chk("miss_cache_we_count", n_cwe, 1);
                            chk("miss_rdata", cpu_rdata, t.exp_rdata);
                        end
                        if (!t.we) last_rdata = t.exp_rdata;
                        chk("hit_count", hit_count, t.exp_hits);
                        chk("miss_count", miss_count, t.exp_misses);
                        $display("txn %s addr=%04h data=%08h hit=%0d lat=%0d hits=%0d misses=%0d",
                                 t.we ? "WR" : "RD", t.addr, t.we ? t.wdata : cpu_rdata,
                                 t.exp_hit, lat, hit_count, miss_count);
                    end
                    n_mem = 0;
                    n_cwe = 0;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [AW-1:0] recent [4];

    initial begin
        int guard;
        bit saw_ack;
        logic [AW-1:0] a;
        bit we;

        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem_phys[i] = 32'h1000_0000 + (i * 32'h0101_0101);
            mem_ref[i]  = mem_phys[i];
        end
        for (int i = 0; i < 4; i++) recent[i] = '0;
        model_reset();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_cache_we", cache_we, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        rst = 1'b0;

        // Reset during MEM_READ abandons the read.
        mem_delay = 8;
        issue(1'b0, 16'h0020, '0, 1'b0, 1'b0);
        guard = 0;
        while (!mem_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_reached_mem_read", mem_req, 1);
        @(negedge clk);
        chk("midrst_miss_before", miss_count, 1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_cpu_ack", cpu_ack, 0);
        chk("midrst_miss_count", miss_count, 0);
        chk("midrst_hit_count", hit_count, 0);
        chk("midrst_ready", cpu_ready, 1);
        rst = 1'b0;
        saw_ack = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_ack || mem_req) saw_ack = 1'b1;
        end
        chk("midrst_no_late_activity", saw_ack, 0);

        // Write then read-hit of 0x0010.
        mem_delay = 2;
        issue(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(1'b0, 16'h0010, '0, 1'b0, 1'b1);
        chk("dir_hit_count_1", hit_count, 1);

        // Cold read of 0x0020 with a 3-cycle memory, then a repeat hit.
        mem_phys[8] = 32'h12345678;
        mem_ref[8]  = 32'h12345678;
        mem_delay = 3;
        issue(1'b0, 16'h0020, '0, 1'b0, 1'b1);
        chk("dir_miss_count_1", miss_count, 1);
        issue(1'b0, 16'h0020, '0, 1'b0, 1'b1);

        // Write 0x0040: counters must not move.
        issue(1'b1, 16'h0040, 32'hA5A5A5A5, 1'b0, 1'b1);
        chk("dir_wr_hits_unchanged", hit_count, 2);
        chk("dir_wr_miss_unchanged", miss_count, 1);

        // cpu_req held through a miss: one accept, one ack.
        spurious_en = 1'b1;
        mem_delay = 4;
        issue(1'b0, 16'h0060, '0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("hold_single_ack", sb_q.size(), 0);

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            we        = ($urandom_range(0, 2) == 0);
            mem_delay = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) a = recent[$urandom_range(0, 3)];
            else                           a = AW'($urandom_range(0, 63) << 2);
            recent[n % 4] = a;
            issue(we, a, $urandom, ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Drive both counters into saturation.
        mem_delay = 1;
        for (int n = 0; n < CMAX + 8; n++) issue(1'b0, 16'h0010, '0, 1'b0, 1'b1);
        for (int n = 0; n < CMAX + 8; n++) issue(1'b0, (n % 2 == 0) ? 16'h0000 : 16'h0020, '0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("sat_hit_model", hit_count, m_hits);
        chk("sat_miss_model", miss_count, m_misses);
        chk("sat_hit_all_ones", hit_count, CMAX);
        chk("sat_miss_all_ones", miss_count, CMAX);
        chk("final_queue_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of every data port.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the byte address width of every address port.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the hit and miss counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 cpu_req  input  1  SHALL request a transaction; sampled only while cpu_ready=1.
REQ-007 cpu_we  input  1  SHALL mark the request as write (1) or read (0).
REQ-008 cpu_addr  input  ADDR_WIDTH  SHALL be the request address.
REQ-009 cpu_wdata  input  DATA_WIDTH  SHALL be the write data.
REQ-010 cpu_ready  output  1  SHALL be high only in IDLE.
REQ-011 cpu_ack  output  1  SHALL pulse for one cycle when a transaction completes.
REQ-012 cpu_rdata  output  DATA_WIDTH  SHALL hold the read result from the ack cycle until the next accepted read.
REQ-013 cache_addr, cache_wdata, cache_we  outputs  ADDR_WIDTH/DATA_WIDTH/1  SHALL drive the direct-mapped cache array.
REQ-014 cache_rdata, cache_hit  inputs  DATA_WIDTH/1  SHALL be the cache's combinational lookup result for cache_addr.
REQ-015 mem_req, mem_we, mem_addr, mem_wdata  outputs  1/1/ADDR_WIDTH/DATA_WIDTH  SHALL form the backing-memory request.
REQ-016 mem_ack, mem_rdata  inputs  1/DATA_WIDTH  SHALL complete a memory request; mem_rdata valid in the mem_ack cycle.
REQ-017 hit_count, miss_count  outputs  CNT_WIDTH  SHALL count read hits and read misses.

Function
REQ-018 The FSM SHALL have states IDLE, COMPARE, MEM_READ, FILL, MEM_WRITE, DONE.
REQ-019 IDLE with cpu_req=1 SHALL latch cpu_we/cpu_addr/cpu_wdata and go to COMPARE; cpu_req while cpu_ready=0 SHALL be ignored.
REQ-020 COMPARE SHALL drive cache_addr with the latched address; read with cache_hit=1: capture cache_rdata into cpu_rdata, increment hit_count, go to DONE.
REQ-021 COMPARE read with cache_hit=0: increment miss_count, go to MEM_READ.
REQ-022 COMPARE write: assert cache_we with latched data (write-allocate), go to MEM_WRITE; counters unchanged.
REQ-023 MEM_READ/MEM_WRITE SHALL hold mem_req=1 with stable mem_we/mem_addr/mem_wdata until the mem_ack cycle, then go to FILL (read) or DONE (write).
REQ-024 On the read mem_ack, mem_rdata SHALL be registered; FILL SHALL assert cache_we with that word and copy it to cpu_rdata, then go to DONE.
REQ-025 DONE SHALL assert cpu_ack for exactly one cycle and return to IDLE.
REQ-026 Latency from accept cycle to cpu_ack: read hit 2 cycles; read miss 3 + N cycles, write 2 + N cycles, where N = cycles mem_req is high including the mem_ack cycle.
REQ-027 mem_ack while mem_req=0 SHALL be ignored.
REQ-028 cache_we SHALL be high only in COMPARE-write and FILL; mem_req only in MEM_READ/MEM_WRITE.
REQ-029 Counters SHALL saturate at all-ones and not wrap.

Reset
REQ-030 rst=1 SHALL force IDLE and zero cpu_ack, cpu_rdata, cache_we, mem_req, mem_we, hit_count, miss_count on the next edge.
REQ-031 rst asserted mid-transaction SHALL abandon it with no cpu_ack and mem_req low the following cycle.

Structure
REQ-032 Package cache_pkg SHALL hold the FSM state enum and default width constants.
REQ-033 One sub-module sat_counter (CNT_WIDTH, inc, saturating) SHALL be instantiated twice; the cache array remains external.

Verification
REQ-034 Read 0x0010 after a write to 0x0010 of 0xDEADBEEF -> cpu_ack 2 cycles after accept, cpu_rdata=0xDEADBEEF, hit_count=1.
REQ-035 Cold read 0x0020, memory returns 0x12345678 after mem_req for 3 cycles -> cache_we in FILL, ack at cycle 6, miss_count=1; repeat read hits.
REQ-036 Write 0x0040=0xA5A5A5A5 -> cache_we in COMPARE, mem_we=1 held until mem_ack, one ack, counters unchanged.
REQ-037 cpu_req held high during a miss -> no second latch until cpu_ready; exactly one ack per accept.
REQ-038 rst pulsed during MEM_READ -> no ack, mem_req low next cycle, counters 0, IDLE.
REQ-039 Force hit_count to all-ones minus 1, issue 3 read hits -> count stays 0xFFFF.
